hbus_arb: RTL and testbench
===========================

// Module: hbus_arb
// PURPOSE
//  Shares one system memory port between N_HARTS harts: round-robin arbitration of L2 (hmem) line fills
//  and 64-bit write-throughs, plus the AMO bus lock (amo_req/amo_ack).
//  Broadcasts a write-invalidate (inv/inv_addr) to every non-writing hart.
//  Sits between the hart array and the external memory controller.
// PARAMETERS
//  N_HARTS  4    number of requesting harts (2..8)
//  LINE_W   `HMEM_LINE  width of a fill line returned on reads
//  ADDR_W   64   address width
// PORTS
//  clk         in   1               system clock; all state updates on posedge
//  rst         in   1               synchronous, active-high reset
//  h_addr      in   N_HARTS*ADDR_W  per-hart request address (slice i = hart i)
//  h_rd        in   N_HARTS         per-hart line-read request, level, held until h_dv
//  h_wr        in   N_HARTS         per-hart 64-bit write request, level, held until h_dv
//  h_data_out  in   N_HARTS*64      per-hart write data
//  h_dv        out  N_HARTS         one-cycle completion pulse to the granted hart
//  h_data_in   out  LINE_W          registered fill data, shared by all harts, valid with h_dv
//  h_amo_req   in   N_HARTS         per-hart bus-lock request, level
//  h_amo_ack   out  N_HARTS         lock granted, held while owner keeps amo_req high
//  h_inv       out  N_HARTS         one-cycle invalidate strobe (all harts except the writer)
//  h_inv_addr  out  ADDR_W          invalidate address, valid with h_inv
//  m_addr      out  ADDR_W          memory-side address (registered)
//  m_rd/m_wr   out  1               memory-side read/write request, held until m_dv
//  m_data_out  out  64              memory-side write data
//  m_data_in   in   LINE_W          memory-side read data, valid with m_dv
//  m_dv        in   1               memory-side completion, one cycle
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, rr pointer=0, no lock owner. Reset mid-transaction drops m_rd/m_wr
//    next cycle; no h_dv is issued for the aborted request.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    - IDLE: eligible = (h_rd|h_wr) masked to the lock owner when locked.
//      Pick the first eligible index at or after ptr+1 (mod N_HARTS). Latch g, addr, data and op.
//      Go to BUSY; m_rd/m_wr go high in the cycle after the request is seen.
//    - BUSY: hold the m_* outputs stable until m_dv.
//      On m_dv: latch m_data_in into h_data_in, set ptr=g, go to RESP.
//    - RESP: h_dv[g]=1 for exactly one cycle.
//      If the op was a write: h_inv=~(1<<g) and h_inv_addr=latched addr in the same cycle.
//      Return to IDLE; the next grant may start in the following cycle.
//  - Latency: request at cycle t, m_rd at t+1, m_dv at t+1+k, h_dv at t+2+k. Minimum 3 cycles with k=1.
//  - h_rd and h_wr both high from one hart: treated as a write (write has priority).
//    The read stays pending and is arbitrated normally afterwards.
//  - Request deasserted mid-BUSY: the transaction completes and h_dv still pulses.
//  - AMO lock:
//    - Evaluated only in IDLE and only when unlocked. Lowest index among h_amo_req wins.
//    - Owner gets h_amo_ack=1 from the next cycle. While locked, only the owner's rd/wr is granted;
//      other harts stall with no h_dv.
//    - Lock releases in the cycle the owner drops amo_req (the next IDLE decision is unlocked); h_amo_ack falls then.
//    - amo_req arriving during BUSY is deferred until the next IDLE.
//  - No hart receives two h_dv pulses for one request; at most one h_dv bit is ever set.
// STRUCTURE
//  - Package hbus_pkg: FSM state localparams (IDLE/BUSY/RESP), op encoding (OP_RD/OP_WR), N_HARTS default.
//  - Sub-module rr_arb: combinational round-robin pick (req, mask, ptr -> one-hot gnt, valid).
//    Pointer register and FSM live in hbus_arb.
// TESTING
//  1. Single read: hart1 h_rd, addr=0x8000_0040, m_dv after 4 cycles with data D
//     -> m_rd high from t+1, h_dv[1] at t+6, h_data_in=D, h_inv=0.
//  2. All 4 harts read continuously from reset -> grant order 1,2,3,0,1,... with no hart served twice in a row.
//  3. Hart2 writes 0xDEAD to 0x1000 -> m_wr with m_data_out=0xDEAD; in RESP h_dv[2]=1, h_inv=4'b1011,
//     h_inv_addr=0x1000.
//  4. Hart0 amo_req while hart3 reads -> h_amo_ack[0]=1, hart3 is never granted until amo_req[0] falls,
//     then hart3 is served next.
//  5. rst asserted while BUSY with m_dv pending -> next cycle m_rd=0, no h_dv, ptr=0;
//     a new request after reset is served normally.
//  6. Hart1 asserts h_rd and h_wr together -> write served first, then read, two separate h_dv pulses.

Source files
------------

// File: rtl/hbus_pkg.sv
// Shared types and defaults for the hart-bus arbiter.
package hbus_pkg;

    localparam int unsigned N_HARTS_DEF = 4;
    localparam int unsigned ADDR_W_DEF  = 64;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned LINE_W_DEF  = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/hbus_arb_rr_arb.sv
// Combinational round-robin pick: first set bit of (req & mask) at or after ptr+1, wrapping.
module rr_arb
    import hbus_pkg::*;
#(
    parameter int unsigned N = N_HARTS_DEF
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 valid
);

    localparam int unsigned PW = $clog2(N);

    logic [N-1:0]   elig;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int unsigned    pos;
    int unsigned    sum;
    logic           found;

    // Rotate the doubled request vector so bit 0 is hart ptr+1, then take the lowest set bit.
    always_comb begin
        elig  = req & mask;
        dbl   = {elig, elig} >> (32'(ptr) + 32'd1);
        rot   = dbl[N-1:0];
        pos   = 0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (rot[i] && !found) begin
                pos   = 32'(i);
                found = 1'b1;
            end
        end
        sum = 32'(ptr) + 32'd1 + pos;
        if (sum >= N) begin
            sum = sum - N;
        end
        valid   = found;
        gnt_idx = PW'(sum);
        gnt     = found ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/hbus_arb.sv
// Round-robin arbiter sharing one memory port between harts, with AMO bus lock and write-invalidate broadcast.
module hbus_arb
    import hbus_pkg::*;
#(
    parameter int unsigned N_HARTS = N_HARTS_DEF,
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_HARTS*ADDR_W-1:0]   h_addr,
    input  logic [N_HARTS-1:0]          h_rd,
    input  logic [N_HARTS-1:0]          h_wr,
    input  logic [N_HARTS*DATA_W-1:0]   h_data_out,
    output logic [N_HARTS-1:0]          h_dv,
    output logic [LINE_W-1:0]           h_data_in,
    input  logic [N_HARTS-1:0]          h_amo_req,
    output logic [N_HARTS-1:0]          h_amo_ack,
    output logic [N_HARTS-1:0]          h_inv,
    output logic [ADDR_W-1:0]           h_inv_addr,
    output logic [ADDR_W-1:0]           m_addr,
    output logic                        m_rd,
    output logic                        m_wr,
    output logic [DATA_W-1:0]           m_data_out,
    input  logic [LINE_W-1:0]           m_data_in,
    input  logic                        m_dv
);

    localparam int unsigned PW = $clog2(N_HARTS);
    localparam logic [N_HARTS-1:0] ONE = N_HARTS'(1);

    state_e              state, state_d;
    op_e                 op, op_d;
    logic [PW-1:0]       ptr, ptr_d, g, g_d, owner, owner_d, owner_now, amo_low;
    logic                locked, locked_d, lock_live, lock_now;
    logic [N_HARTS-1:0]  mask, arb_gnt, h_dv_d, h_amo_ack_d, h_inv_d;
    logic [PW-1:0]       arb_idx;
    logic                arb_valid;
    logic [LINE_W-1:0]   h_data_in_d;
    logic [ADDR_W-1:0]   h_inv_addr_d, m_addr_d;
    logic                m_rd_d, m_wr_d;
    logic [DATA_W-1:0]   m_data_out_d;

    rr_arb #(.N(N_HARTS)) u_rr (
        .req     (h_rd | h_wr),
        .mask    (mask),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    // Lock ownership: held while owner keeps amo_req; a new owner is only chosen in IDLE.
    always_comb begin
        amo_low = '0;
        for (int i = int'(N_HARTS) - 1; i >= 0; i--) begin
            if (h_amo_req[i]) begin
                amo_low = PW'(i);
            end
        end
        lock_live   = locked && h_amo_req[owner];
        lock_now    = lock_live || ((state == IDLE) && (|h_amo_req));
        owner_now   = lock_live ? owner : amo_low;
        mask        = lock_now ? (ONE << owner_now) : '1;
        locked_d    = lock_now;
        owner_d     = lock_now ? owner_now : owner;
        h_amo_ack_d = lock_now ? (ONE << owner_now) : '0;
    end

    always_comb begin
        state_d      = state;
        op_d         = op;
        ptr_d        = ptr;
        g_d          = g;
        h_dv_d       = '0;
        h_inv_d      = '0;
        h_inv_addr_d = h_inv_addr;
        h_data_in_d  = h_data_in;
        m_addr_d     = m_addr;
        m_rd_d       = m_rd;
        m_wr_d       = m_wr;
        m_data_out_d = m_data_out;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    g_d          = arb_idx;
                    op_d         = h_wr[arb_idx] ? OP_WR : OP_RD;
                    m_addr_d     = h_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
                    m_data_out_d = h_data_out[32'(arb_idx)*DATA_W +: DATA_W];
                    m_wr_d       = h_wr[arb_idx];
                    m_rd_d       = !h_wr[arb_idx];
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (m_dv) begin
                    h_data_in_d = m_data_in;
                    ptr_d       = g;
                    h_dv_d      = ONE << g;
                    if (op == OP_WR) begin
                        h_inv_d      = ~(ONE << g);
                        h_inv_addr_d = m_addr;
                    end
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_RD;
            ptr        <= '0;
            g          <= '0;
            locked     <= 1'b0;
            owner      <= '0;
            h_dv       <= '0;
            h_amo_ack  <= '0;
            h_inv      <= '0;
            h_inv_addr <= '0;
            h_data_in  <= '0;
            m_addr     <= '0;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            m_data_out <= '0;
        end else begin
            state      <= state_d;
            op         <= op_d;
            ptr        <= ptr_d;
            g          <= g_d;
            locked     <= locked_d;
            owner      <= owner_d;
            h_dv       <= h_dv_d;
            h_amo_ack  <= h_amo_ack_d;
            h_inv      <= h_inv_d;
            h_inv_addr <= h_inv_addr_d;
            h_data_in  <= h_data_in_d;
            m_addr     <= m_addr_d;
            m_rd       <= m_rd_d;
            m_wr       <= m_wr_d;
            m_data_out <= m_data_out_d;
        end
    end

endmodule

// File: tb/tb_hbus_arb.sv
// Bench for hbus_arb: directed scenarios plus random traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_hbus_arb;
    import hbus_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned LW = 256;
    localparam int unsigned AW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*AW-1:0]   h_addr;
    logic [N-1:0]      h_rd, h_wr, h_amo_req;
    logic [N*64-1:0]   h_data_out;
    logic [N-1:0]      h_dv, h_amo_ack, h_inv;
    logic [LW-1:0]     h_data_in, m_data_in;
    logic [AW-1:0]     h_inv_addr, m_addr;
    logic              m_rd, m_wr, m_dv;
    logic [63:0]       m_data_out;

    hbus_arb #(.N_HARTS(N), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr),
        .h_data_out(h_data_out), .h_dv(h_dv), .h_data_in(h_data_in),
        .h_amo_req(h_amo_req), .h_amo_ack(h_amo_ack), .h_inv(h_inv),
        .h_inv_addr(h_inv_addr), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
        .m_data_out(m_data_out), .m_data_in(m_data_in), .m_dv(m_dv)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h @%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h @%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, completion announced the cycle after m_dv.
    bit          mdl_ok = 0;
    bit          t_active, t_resp, t_wr;
    int          t_hart, rr_last, lock_owner;
    logic [AW-1:0] t_addr;
    logic [N-1:0]  e_h_dv, e_ack, e_inv;
    logic [LW-1:0] e_data;
    logic [AW-1:0] e_inv_addr, e_m_addr;
    logic          e_m_rd, e_m_wr;
    logic [63:0]   e_m_dout;

    initial forever begin
        int  pick, own_now, h;
        bit  idle, lock_live;
        @(posedge clk);
        if (rst) begin
            mdl_ok = 1; t_active = 0; t_resp = 0; t_wr = 0; t_hart = 0;
            rr_last = 0; lock_owner = -1; t_addr = '0;
            e_h_dv = '0; e_ack = '0; e_inv = '0; e_data = '0; e_inv_addr = '0;
            e_m_addr = '0; e_m_rd = 0; e_m_wr = 0; e_m_dout = '0;
        end else if (mdl_ok) begin
            e_h_dv = '0;
            e_inv  = '0;
            idle = !t_active && !t_resp;
            lock_live = (lock_owner >= 0) && h_amo_req[lock_owner];
            own_now = lock_live ? lock_owner : -1;
            if (!lock_live && idle) begin
                for (int i = int'(N) - 1; i >= 0; i--) if (h_amo_req[i]) own_now = i;
            end
            if (t_active) begin
                if (m_dv) begin
                    e_data = m_data_in;
                    e_h_dv = '0;
                    e_h_dv[t_hart] = 1'b1;
                    if (t_wr) begin
                        e_inv = '1;
                        e_inv[t_hart] = 1'b0;
                        e_inv_addr = t_addr;
                    end
                    rr_last = t_hart;
                    e_m_rd = 0; e_m_wr = 0;
                    t_active = 0; t_resp = 1;
                end
            end else if (t_resp) begin
                t_resp = 0;
            end else begin
                pick = -1;
                for (int k = 1; k <= int'(N); k++) begin
                    h = (rr_last + k) % int'(N);
                    if (pick < 0 && (h_rd[h] || h_wr[h]) && (own_now < 0 || own_now == h)) pick = h;
                end
                if (pick >= 0) begin
                    t_hart = pick;
                    t_wr = h_wr[pick];
                    t_addr = h_addr[pick*AW +: AW];
                    e_m_addr = t_addr;
                    e_m_dout = h_data_out[pick*64 +: 64];
                    e_m_wr = t_wr;
                    e_m_rd = !t_wr;
                    t_active = 1;
                end
            end
            lock_owner = own_now;
            e_ack = '0;
            if (own_now >= 0) e_ack[own_now] = 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (mdl_ok) begin
            chk("h_dv", 64'(h_dv), 64'(e_h_dv));
            chk("h_amo_ack", 64'(h_amo_ack), 64'(e_ack));
            chk("h_inv", 64'(h_inv), 64'(e_inv));
            chk("m_rd", 64'(m_rd), 64'(e_m_rd));
            chk("m_wr", 64'(m_wr), 64'(e_m_wr));
            if (e_h_dv != '0) chkw("h_data_in", h_data_in, e_data);
            if (e_inv != '0) chk("h_inv_addr", h_inv_addr, e_inv_addr);
            if (e_m_rd || e_m_wr) begin
                chk("m_addr", m_addr, e_m_addr);
                chk("m_data_out", m_data_out, e_m_dout);
            end
        end
    end

    // Memory responder: m_dv one cycle, mem_lat cycles after the request is first seen (0 = random 1..5).
    int          mem_lat = 0;
    bit          mem_fix = 0;
    logic [LW-1:0] mem_d;
    initial begin
        int cnt;
        bit armed, done;
        m_dv = 1'b0; m_data_in = '0; armed = 0; done = 0; cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_dv = 1'b0; armed = 0; done = 0;
            end else if (m_dv) begin
                m_dv = 1'b0; done = 1;
            end else if (armed) begin
                cnt--;
                if (cnt <= 0) begin
                    armed = 0;
                    m_dv = 1'b1;
                    if (mem_fix) m_data_in = mem_d;
                    else for (int i = 0; i < int'(LW) / 32; i++) m_data_in[i*32 +: 32] = $urandom;
                end
            end else if ((m_rd || m_wr) && !done) begin
                armed = 1;
                cnt = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 5));
            end
            if (!(m_rd || m_wr)) done = 0;
        end
    end

    bit rand_mode = 0;
    bit last_wr = 0;

    // One cycle of hart behaviour: retire served requests, optionally issue random traffic.
    task automatic step();
        int r;
        @(negedge clk);
        if (m_rd || m_wr) last_wr = m_wr;
        for (int i = 0; i < int'(N); i++) begin
            if (h_dv[i]) begin
                if (h_wr[i]) h_wr[i] = 1'b0;
                else h_rd[i] = 1'b0;
            end
            if (rand_mode) begin
                if (!h_rd[i] && !h_wr[i] && $urandom_range(0, 3) == 0) begin
                    r = int'($urandom_range(0, 3));
                    h_rd[i] = (r != 2);
                    h_wr[i] = (r >= 2);
                    h_addr[i*AW +: AW] = {$urandom, $urandom};
                    h_data_out[i*64 +: 64] = {$urandom, $urandom};
                end else if ((h_rd[i] || h_wr[i]) && $urandom_range(0, 63) == 0) begin
                    h_rd[i] = 1'b0;
                    h_wr[i] = 1'b0;
                end
                if ($urandom_range(0, 19) == 0) h_amo_req[i] = ~h_amo_req[i];
            end
        end
    endtask

    task automatic wait_dv(input int hart, input int budget, output int cyc, output bit got_wr);
        cyc = 0;
        got_wr = 0;
        while (cyc < budget) begin
            step();
            cyc++;
            if (h_dv[hart]) begin
                got_wr = last_wr;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_dv_hart%0d no completion within %0d cycles", hart, budget);
        cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_mode = 0;
        h_rd = '0; h_wr = '0; h_amo_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    int exp_order[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int  c, got, k, n;
        bit  w;
        rst = 1'b1;
        h_rd = '0; h_wr = '0; h_amo_req = '0; h_addr = '0; h_data_out = '0;
        step();
        step();
        chk("rst_h_dv", 64'(h_dv), 64'd0);
        chk("rst_m_rd", 64'(m_rd), 64'd0);
        chk("rst_ack", 64'(h_amo_ack), 64'd0);
        chk("rst_inv", 64'(h_inv), 64'd0);
        rst = 1'b0;

        // Single read with k=4 and fixed fill data.
        mem_lat = 4; mem_fix = 1;
        mem_d = {4{64'hA5A5_0123_4567_89AB}};
        h_addr[1*AW +: AW] = 64'h8000_0040;
        h_rd[1] = 1'b1;
        step();
        chk("t1_m_rd", 64'(m_rd), 64'd1);
        chk("t1_m_addr", m_addr, 64'h8000_0040);
        wait_dv(1, 20, c, w);
        chk("t1_latency", 64'(c + 1), 64'd6);
        chk("t1_h_dv", 64'(h_dv), 64'h2);
        chkw("t1_data", h_data_in, {4{64'hA5A5_0123_4567_89AB}});
        chk("t1_inv", 64'(h_inv), 64'd0);
        mem_fix = 0; mem_lat = 0;

        // Continuous reads from reset rotate 1,2,3,0.
        do_reset();
        h_rd = '1;
        k = 0; c = 0;
        while (k < 8 && c < 200) begin
            step();
            c++;
            if (h_dv != '0) begin
                got = -1;
                for (int i = 0; i < int'(N); i++) if (h_dv[i]) got = i;
                chk("t2_grant", 64'(got), 64'(exp_order[k]));
                k++;
            end
            h_rd = '1;
        end
        if (k < 8) begin
            checks++; failures++;
            $display("FAIL t2_timeout grants=%0d required=8", k);
        end

        // Write-through with invalidate.
        do_reset();
        h_addr[2*AW +: AW] = 64'h1000;
        h_data_out[2*64 +: 64] = 64'hDEAD;
        h_wr[2] = 1'b1;
        step();
        chk("t3_m_wr", 64'(m_wr), 64'd1);
        chk("t3_m_data_out", m_data_out, 64'hDEAD);
        chk("t3_m_addr", m_addr, 64'h1000);
        wait_dv(2, 20, c, w);
        chk("t3_h_dv", 64'(h_dv), 64'h4);
        chk("t3_inv", 64'(h_inv), 64'hB);
        chk("t3_inv_addr", h_inv_addr, 64'h1000);

        // AMO lock by hart0 blocks hart3 until released.
        do_reset();
        h_amo_req[0] = 1'b1;
        h_rd[3] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (h_dv[3]) n++;
        end
        chk("t4_hart3_stalled", 64'(n), 64'd0);
        chk("t4_ack", 64'(h_amo_ack), 64'h1);
        h_rd[0] = 1'b1;
        wait_dv(0, 20, c, w);
        chk("t4_owner_served", 64'(c > 0), 64'd1);
        h_amo_req[0] = 1'b0;
        step();
        chk("t4_ack_drop", 64'(h_amo_ack), 64'd0);
        wait_dv(3, 20, c, w);
        chk("t4_hart3_served", 64'(c > 0), 64'd1);

        // Reset during BUSY aborts with no completion; pointer returns to 0.
        do_reset();
        mem_lat = 8;
        h_rd[2] = 1'b1;
        step(); step(); step();
        chk("t5_busy_m_rd", 64'(m_rd), 64'd1);
        rst = 1'b1;
        h_rd = '0;
        step();
        chk("t5_abort_m_rd", 64'(m_rd), 64'd0);
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (h_dv != '0) n++;
        end
        chk("t5_no_h_dv", 64'(n), 64'd0);
        mem_lat = 0;
        h_rd[0] = 1'b1; h_rd[1] = 1'b1;
        c = 0;
        while (h_dv == '0 && c < 30) begin
            step();
            c++;
        end
        chk("t5_first_grant", 64'(h_dv), 64'h2);

        // Read+write from one hart: write first, then read.
        do_reset();
        h_rd[1] = 1'b1; h_wr[1] = 1'b1;
        wait_dv(1, 20, c, w);
        chk("t6_first_is_write", 64'(w), 64'd1);
        wait_dv(1, 20, c, w);
        chk("t6_second_is_read", 64'(w), 64'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (h_dv != '0) n++;
        end
        chk("t6_no_extra_dv", 64'(n), 64'd0);

        // Random traffic with locks, drops and variable memory latency.
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rand_mode = 0;
        h_rd = '0; h_wr = '0; h_amo_req = '0;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
